// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the ID-stage helpers (scoreboard, forwarding).
//   NUM_REGS   : number of architectural integer registers
//   OP_*       : 7-bit major opcodes that the decode helpers recognise
//   src_use_t  : which operand fields an opcode actually uses
package rv32_pkg;

  localparam int NUM_REGS = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
  } src_use_t;

endpackage

// File: rtl/id_scoreboard_if.sv
// Signal bundle between the ID stage and the hazard scoreboard.
//   master : ID/WB side, drives the decoded fields and the writeback pair
//   slave  : scoreboard side, returns stall_o, issue_o and pending_o
interface id_scoreboard_if;

  logic                          id_valid;
  logic                          hold_i;
  logic                          flush_i;
  logic [6:0]                    OPCODE_ID;
  logic [4:0]                    RS1_ID;
  logic [4:0]                    RS2_ID;
  logic [4:0]                    RD_ID;
  logic                          RegWrite_WB;
  logic [4:0]                    RD_WB;
  logic                          stall_o;
  logic                          issue_o;
  logic [rv32_pkg::NUM_REGS-1:0] pending_o;

  modport master (
    output id_valid, hold_i, flush_i, OPCODE_ID, RS1_ID, RS2_ID, RD_ID,
           RegWrite_WB, RD_WB,
    input  stall_o, issue_o, pending_o
  );

  modport slave (
    input  id_valid, hold_i, flush_i, OPCODE_ID, RS1_ID, RS2_ID, RD_ID,
           RegWrite_WB, RD_WB,
    output stall_o, issue_o, pending_o
  );

endinterface

// File: rtl/rv_src_decode.sv
// Opcode -> operand usage decode, shared by the scoreboard and forwarding unit.
//   i_opcode : 7-bit major opcode
//   o_use    : {uses_rs1, uses_rs2, writes_rd}; unknown opcodes use nothing
module rv_src_decode
  import rv32_pkg::*;
(
  input  logic [6:0] i_opcode,
  output src_use_t   o_use
);

  always_comb begin
    // NOTE: default every output before the case so no path leaves it unassigned (no latch).
    o_use = '0;
    case (i_opcode)
      OP_R:      o_use = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b1};
      OP_IMM:    o_use = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1};
      OP_LOAD:   o_use = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1};
      OP_STORE:  o_use = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0};
      OP_BRANCH: o_use = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0};
      OP_JALR:   o_use = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1};
      OP_JAL:    o_use = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b1};
      OP_LUI:    o_use = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b1};
      OP_AUIPC:  o_use = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b1};
      default:   o_use = '0;
    endcase
  end

endmodule

// File: rtl/id_scoreboard.sv
// Register-hazard scoreboard for the RV32I ID stage. Keeps an in-flight write
// count per architectural register; ID issue increments, WB retire decrements.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   sb (slave) : ID fields + WB pair in; stall_o / issue_o / pending_o out
// Parameters:
//   CNT_W      : width of each in-flight counter (saturates at 2^CNT_W-1)
//   WB_BYPASS  : 1 lets a retiring write release a source stall in the same cycle
module id_scoreboard
  import rv32_pkg::*;
#(
  parameter int CNT_W     = 2,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  id_scoreboard_if.slave  sb
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_REGS-1:0][CNT_W-1:0] w_count;
  logic [NUM_REGS-1:0]            w_wb_dec;
  logic [NUM_REGS-1:0]            w_inc;
  logic [NUM_REGS-1:0]            w_pending;
  logic [CNT_W-1:0]               w_eff_rs1;
  logic [CNT_W-1:0]               w_eff_rs2;
  logic                           w_haz;
  logic                           w_full;
  logic                           w_live;
  logic                           w_stall;
  logic                           w_issue;
  src_use_t                       w_use;

  rv_src_decode u_src_decode (
    .i_opcode (sb.OPCODE_ID),
    .o_use    (w_use)
  );

  // A retire only counts against a register that actually has a write in
  // flight; this is what keeps the counters from underflowing. x0 never counts.
  always_comb begin
    w_wb_dec  = '0;
    w_pending = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      w_wb_dec[r]  = sb.RegWrite_WB && (sb.RD_WB == 5'(r)) && (w_count[r] != '0);
      w_pending[r] = (w_count[r] != '0);
    end
  end

  // wb_dec implies count != 0, so the subtraction cannot wrap.
  assign w_eff_rs1 = w_count[sb.RS1_ID] - CNT_W'(WB_BYPASS && w_wb_dec[sb.RS1_ID]);
  assign w_eff_rs2 = w_count[sb.RS2_ID] - CNT_W'(WB_BYPASS && w_wb_dec[sb.RS2_ID]);

  assign w_haz  = (w_use.uses_rs1 && (w_eff_rs1 != '0)) ||
                  (w_use.uses_rs2 && (w_eff_rs2 != '0));
  // A same-cycle retire frees a slot regardless of WB_BYPASS, so a saturated
  // destination can still accept the new write.
  assign w_full = w_use.writes_rd && (sb.RD_ID != 5'd0) &&
                  (w_count[sb.RD_ID] == CNT_MAX) && !w_wb_dec[sb.RD_ID];

  assign w_live  = sb.id_valid && !sb.flush_i;
  assign w_stall = w_live && (w_haz || w_full);
  assign w_issue = w_live && !sb.hold_i && !w_stall;

  always_comb begin
    w_inc = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      w_inc[r] = w_issue && w_use.writes_rd && (sb.RD_ID == 5'(r));
    end
  end

  assign w_count[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;

    // NOTE: these are individual flops, not a RAM, so each one takes the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_inc[r] != w_wb_dec[r]) begin
        // NOTE: non-blocking so every counter samples the pre-edge state.
        r_cnt <= w_inc[r] ? r_cnt + CNT_W'(1) : r_cnt - CNT_W'(1);
      end
    end

    assign w_count[r] = r_cnt;
  end

  assign sb.stall_o   = w_stall;
  assign sb.issue_o   = w_issue;
  assign sb.pending_o = w_pending;

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard. Two instances (WB_BYPASS=1 and 0) see
// identical stimulus; a per-register in-flight count model predicts each one.
module tb_id_scoreboard;
  import rv32_pkg::*;

  logic clk;
  logic rst_n;

  id_scoreboard_if if_b ();
  id_scoreboard_if if_n ();

  id_scoreboard #(.CNT_W(2), .WB_BYPASS(1'b1)) u_dut_b (.clk(clk), .rst_n(rst_n), .sb(if_b));
  id_scoreboard #(.CNT_W(2), .WB_BYPASS(1'b0)) u_dut_n (.clk(clk), .rst_n(rst_n), .sb(if_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         v, h, f;
    logic [6:0] op;
    logic [4:0] rs1, rs2, rd;
    bit         ww;
    logic [4:0] wrd;
  } stim_t;

  localparam int MAXC = 3;

  int    n_pass  = 0;
  int    n_total = 0;
  stim_t cur;
  int    cnt     [2][32];   // [0]: bypass instance, [1]: no-bypass instance
  int    nxt     [2][32];
  bit    exp_st  [2];
  bit    exp_is  [2];
  bit [31:0] exp_pd [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic stim_t mk(bit v, bit h, bit f, logic [6:0] op, logic [4:0] rs1,
                               logic [4:0] rs2, logic [4:0] rd, bit ww, logic [4:0] wrd);
    stim_t s;
    s.v = v; s.h = h; s.f = f; s.op = op; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
    s.ww = ww; s.wrd = wrd;
    return s;
  endfunction

  function automatic bit reads1(logic [6:0] op);
    return op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
  endfunction
  function automatic bit reads2(logic [6:0] op);
    return op inside {OP_R, OP_STORE, OP_BRANCH};
  endfunction
  function automatic bit writes(logic [6:0] op);
    return op inside {OP_R, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  endfunction

  // Reference: what instance k should show this cycle and its counts after the edge.
  task automatic model_eval(input int k);
    int  dec [32];
    int  e1, e2;
    bit  haz, full, live;
    for (int r = 0; r < 32; r++)
      dec[r] = (cur.ww && int'(cur.wrd) == r && r != 0 && cnt[k][r] > 0) ? 1 : 0;
    e1   = cnt[k][cur.rs1] - ((k == 0) ? dec[cur.rs1] : 0);
    e2   = cnt[k][cur.rs2] - ((k == 0) ? dec[cur.rs2] : 0);
    haz  = (reads1(cur.op) && e1 != 0) || (reads2(cur.op) && e2 != 0);
    full = writes(cur.op) && cur.rd != 0 && cnt[k][cur.rd] == MAXC && dec[cur.rd] == 0;
    live = cur.v && !cur.f;
    exp_st[k] = live && (haz || full);
    exp_is[k] = live && !cur.h && !exp_st[k];
    for (int r = 0; r < 32; r++) begin
      exp_pd[k][r] = (cnt[k][r] != 0);
      nxt[k][r] = cnt[k][r] - dec[r] +
                  ((exp_is[k] && writes(cur.op) && int'(cur.rd) == r && r != 0) ? 1 : 0);
    end
  endtask

  task automatic drive(input stim_t s);
    cur = s;
    if_b.id_valid = s.v;  if_n.id_valid = s.v;
    if_b.hold_i   = s.h;  if_n.hold_i   = s.h;
    if_b.flush_i  = s.f;  if_n.flush_i  = s.f;
    if_b.OPCODE_ID = s.op;  if_n.OPCODE_ID = s.op;
    if_b.RS1_ID = s.rs1;  if_n.RS1_ID = s.rs1;
    if_b.RS2_ID = s.rs2;  if_n.RS2_ID = s.rs2;
    if_b.RD_ID  = s.rd;   if_n.RD_ID  = s.rd;
    if_b.RegWrite_WB = s.ww;  if_n.RegWrite_WB = s.ww;
    if_b.RD_WB  = s.wrd;  if_n.RD_WB  = s.wrd;
  endtask

  // Drive at posedge+1, compare at posedge+4.
  task automatic apply(input stim_t s);
    drive(s);
    #3;
    model_eval(0);
    model_eval(1);
    check("stall_b", 32'(if_b.stall_o), 32'(exp_st[0]));
    check("issue_b", 32'(if_b.issue_o), 32'(exp_is[0]));
    check("pend_b",  if_b.pending_o,    exp_pd[0]);
    check("stall_n", 32'(if_n.stall_o), 32'(exp_st[1]));
    check("issue_n", 32'(if_n.issue_o), 32'(exp_is[1]));
    check("pend_n",  if_n.pending_o,    exp_pd[1]);
  endtask

  task automatic tick();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++) cnt[k][r] = nxt[k][r];
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 5'd0));
    #1;
    check("rst_pend_b",  if_b.pending_o, 32'd0);
    check("rst_pend_n",  if_n.pending_o, 32'd0);
    check("rst_stall_b", 32'(if_b.stall_o), 32'd0);
    check("rst_issue_b", 32'(if_b.issue_o), 32'd0);
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++) cnt[k][r] = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 9) < 8) return 5'($urandom_range(0, 4));
    return 5'($urandom_range(0, 31));
  endfunction

  function automatic logic [6:0] pick_op();
    logic [6:0] ops [11];
    ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
            OP_LUI, OP_AUIPC, OP_FENCE, OP_SYS};
    return ops[$urandom_range(0, 10)];
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 5'd0));
    #1;
    do_reset();

    // Scenario: RAW on x5, released by WB (same cycle with bypass, one later without).
    apply(mk(1, 0, 0, OP_R, 5'd1, 5'd2, 5'd5, 0, 5'd0));
    check("s1_first_issue", 32'(if_b.issue_o), 32'd1);
    tick();
    apply(mk(1, 0, 0, OP_R, 5'd5, 5'd1, 5'd6, 0, 5'd0));
    check("s1_raw_stall_b", 32'(if_b.stall_o), 32'd1);
    check("s1_pend5_b",     32'(if_b.pending_o[5]), 32'd1);
    check("s2_raw_stall_n", 32'(if_n.stall_o), 32'd1);
    tick();
    apply(mk(1, 0, 0, OP_R, 5'd5, 5'd1, 5'd6, 1, 5'd5));
    check("s1_bypass_stall_b", 32'(if_b.stall_o), 32'd0);
    check("s1_bypass_issue_b", 32'(if_b.issue_o), 32'd1);
    check("s2_wb_stall_n",     32'(if_n.stall_o), 32'd1);
    tick();
    apply(mk(1, 0, 0, OP_R, 5'd5, 5'd1, 5'd6, 0, 5'd0));
    check("s2_release_stall_n", 32'(if_n.stall_o), 32'd0);
    check("s2_release_issue_n", 32'(if_n.issue_o), 32'd1);
    tick();

    // Scenario: x7 counter saturation.
    do_reset();
    repeat (3) begin
      apply(mk(1, 0, 0, OP_R, 5'd0, 5'd0, 5'd7, 0, 5'd0));
      tick();
    end
    apply(mk(1, 0, 0, OP_R, 5'd0, 5'd0, 5'd7, 0, 5'd0));
    check("s3_full_stall_b", 32'(if_b.stall_o), 32'd1);
    check("s3_full_stall_n", 32'(if_n.stall_o), 32'd1);
    tick();
    apply(mk(1, 0, 0, OP_R, 5'd0, 5'd0, 5'd7, 1, 5'd7));
    check("s3_full_wb_issue_b", 32'(if_b.issue_o), 32'd1);
    check("s3_full_wb_issue_n", 32'(if_n.issue_o), 32'd1);
    tick();
    apply(mk(1, 0, 0, OP_R, 5'd0, 5'd0, 5'd7, 0, 5'd0));
    check("s3_still_full_b", 32'(if_b.stall_o), 32'd1);
    tick();

    // Scenario: inc and dec on x9 together keep the count at 1.
    do_reset();
    apply(mk(1, 0, 0, OP_IMM, 5'd0, 5'd0, 5'd9, 0, 5'd0));
    tick();
    apply(mk(1, 0, 0, OP_IMM, 5'd0, 5'd0, 5'd9, 1, 5'd9));
    check("s4_issue_b", 32'(if_b.issue_o), 32'd1);
    tick();
    apply(mk(0, 0, 0, 7'd0, 5'd0, 5'd0, 5'd0, 1, 5'd9));
    check("s4_pend9_b", 32'(if_b.pending_o[9]), 32'd1);
    tick();
    apply(mk(0, 0, 0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 5'd0));
    check("s4_pend9_gone_b", 32'(if_b.pending_o[9]), 32'd0);
    tick();

    // Scenario: x0 is never tracked; WB to idle x12 is ignored.
    do_reset();
    apply(mk(1, 0, 0, OP_R, 5'd1, 5'd2, 5'd0, 0, 5'd0));
    tick();
    apply(mk(1, 0, 0, OP_R, 5'd0, 5'd0, 5'd1, 0, 5'd0));
    check("s5_x0_stall_b", 32'(if_b.stall_o), 32'd0);
    check("s5_x0_pend_b",  if_b.pending_o, 32'd0);
    tick();
    apply(mk(0, 0, 0, 7'd0, 5'd0, 5'd0, 5'd0, 1, 5'd12));
    tick();
    apply(mk(1, 0, 0, OP_LUI, 5'd0, 5'd0, 5'd12, 0, 5'd0));
    check("s5_idle_wb_pend_b", if_b.pending_o, 32'h0000_0002);
    tick();

    // Scenario: flush squashes a hazard; reset mid-run clears pending at once.
    do_reset();
    apply(mk(1, 0, 0, OP_R, 5'd1, 5'd2, 5'd5, 0, 5'd0));
    tick();
    apply(mk(1, 0, 1, OP_R, 5'd5, 5'd1, 5'd6, 0, 5'd0));
    check("s6_flush_stall_b", 32'(if_b.stall_o), 32'd0);
    check("s6_flush_issue_b", 32'(if_b.issue_o), 32'd0);
    tick();
    apply(mk(0, 0, 0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 5'd0));
    check("s6_flush_pend_b", if_b.pending_o, 32'h0000_0020);
    do_reset();

    // Randomised traffic biased toward a few registers so hazards are common.
    for (int i = 0; i < 500; i++) begin
      stim_t s;
      s.v   = ($urandom_range(0, 99) < 85);
      s.h   = ($urandom_range(0, 99) < 15);
      s.f   = ($urandom_range(0, 99) < 10);
      s.op  = pick_op();
      s.rs1 = pick_reg();
      s.rs2 = pick_reg();
      s.rd  = pick_reg();
      s.ww  = ($urandom_range(0, 99) < 60);
      s.wrd = pick_reg();
      apply(s);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
